// File: rtl/text_ram_arbiter.sv
// Port arbiter and fill sequencer in front of the 3072x16 text RAM (write port A, read port B).
// Optional starvation guard for CPU reads: define TEXT_RAM_ARB_STARVE_GUARD_EN.
module text_ram_arbiter #(
    parameter int DEPTH    = 3072,
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    output logic          vid_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] ram_ada,
    output logic [DW-1:0] ram_din,
    output logic          ram_cea,
    output logic [AW-1:0] ram_adb,
    output logic          ram_ceb,
    output logic          ram_oce,
    output logic          ram_reset,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {C_IDLE, C_RD1, C_RD2, C_ACK} cpu_state_t;
    typedef enum logic [1:0] {F_IDLE, F_RUN, F_DONE} fill_state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    cpu_state_t  cpu_state, cpu_next;
    fill_state_t fill_state, fill_next;
    logic [AW-1:0] fill_addr, fill_left;
    logic [DW-1:0] fill_val;
    logic cpu_rd_pending, cpu_rd_grant, cpu_wr_issue, cpu_steal, vid_grant;
    logic vid_p1, vid_oor_p1;

    assign cpu_rd_pending = (cpu_state == C_IDLE) && cpu_req && !cpu_we;
    assign cpu_wr_issue   = (cpu_state == C_IDLE) && cpu_req && cpu_we && (fill_state != F_RUN);
    assign vid_grant      = vid_req && !cpu_steal;
    assign cpu_rd_grant   = cpu_rd_pending && !vid_grant;

`ifdef TEXT_RAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] starve_cnt;
    logic          miss_p1, vid_miss_q;

    // After MAX_WAIT consecutive losses the CPU read takes the next port B slot outright.
    assign cpu_steal = cpu_rd_pending && (starve_cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt <= '0;
            miss_p1    <= 1'b0;
            vid_miss_q <= 1'b0;
        end else begin
            if (cpu_rd_pending && vid_req && !cpu_steal) starve_cnt <= starve_cnt + 1'b1;
            else                                         starve_cnt <= '0;
            miss_p1    <= vid_req && cpu_steal;
            vid_miss_q <= miss_p1;
        end
    end

    assign vid_miss = vid_miss_q;
`else
    assign cpu_steal = 1'b0;
    assign vid_miss  = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_state  <= C_IDLE;
            fill_state <= F_IDLE;
        end else begin
            cpu_state  <= cpu_next;
            fill_state <= fill_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cpu_next = cpu_state;
        case (cpu_state)
            C_IDLE:  if (cpu_wr_issue) cpu_next = C_ACK;
                     else if (cpu_rd_grant) cpu_next = C_RD1;
            C_RD1:   cpu_next = C_RD2;
            C_RD2:   cpu_next = C_IDLE;
            C_ACK:   cpu_next = C_IDLE;
            default: cpu_next = C_IDLE;
        endcase
    end

    always_comb begin
        fill_next = fill_state;
        case (fill_state)
            F_IDLE:  if (fill_start)
                         fill_next = (fill_len == '0 || !in_range(fill_base)) ? F_DONE : F_RUN;
            F_RUN:   if (fill_left == AW'(1) || fill_addr == AW'(DEPTH - 1)) fill_next = F_DONE;
            F_DONE:  fill_next = F_IDLE;
            default: fill_next = F_IDLE;
        endcase
    end

    // NOTE: pure datapath registers carry no reset; they are only read in F_RUN, after a load.
    always_ff @(posedge clk) begin
        if (fill_state == F_IDLE && fill_start) begin
            fill_addr <= fill_base;
            fill_left <= fill_len;
            fill_val  <= fill_value;
        end else if (fill_state == F_RUN) begin
            fill_addr <= fill_addr + 1'b1;
            fill_left <= fill_left - 1'b1;
        end
    end

    // RAM enables are gated by resetn so nothing issues during a reset cycle.
    always_comb begin
        ram_ada = cpu_addr;
        ram_din = cpu_wdata;
        ram_cea = 1'b0;
        if (fill_state == F_RUN) begin
            ram_ada = fill_addr;
            ram_din = fill_val;
            ram_cea = resetn;
        end else if (cpu_wr_issue) begin
            ram_cea = resetn && in_range(cpu_addr);
        end
        ram_adb = vid_grant ? vid_addr : cpu_addr;
        ram_ceb = resetn && ((vid_grant && in_range(vid_addr)) ||
                             (cpu_rd_grant && in_range(cpu_addr)));
    end

    // Read results: grant at T, RAM data at T+1, registered output at T+2.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vid_p1     <= 1'b0;
            vid_oor_p1 <= 1'b0;
            vid_valid  <= 1'b0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
        end else begin
            vid_p1     <= vid_grant;
            vid_oor_p1 <= !in_range(vid_addr);
            vid_valid  <= vid_p1;
            if (vid_p1) vid_data <= vid_oor_p1 ? '0 : ram_dout;
            if (cpu_state == C_RD1) cpu_rdata <= in_range(cpu_addr) ? ram_dout : '0;
        end
    end

    assign cpu_ack   = resetn && (cpu_state == C_RD2 || cpu_state == C_ACK);
    assign fill_busy = resetn && (fill_state == F_RUN);
    assign fill_done = resetn && (fill_state == F_DONE);
    assign ram_oce   = 1'b1;
    assign ram_reset = ~resetn;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Self-checking bench for text_ram_arbiter with a behavioural 3072x16 dual-port RAM model.
// Starvation-guard expectations follow TEXT_RAM_ARB_STARVE_GUARD_EN (MAX_WAIT = 8).
module tb_text_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int DEPTH = 3072;

    logic          clk, resetn;
    logic          vid_req, vid_valid, vid_miss;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          fill_start, fill_busy, fill_done;
    logic [AW-1:0] fill_base, fill_len;
    logic [DW-1:0] fill_value;
    logic [AW-1:0] ram_ada, ram_adb;
    logic [DW-1:0] ram_din, ram_dout;
    logic          ram_cea, ram_ceb, ram_oce, ram_reset;

    text_ram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .vid_data(vid_data), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_ada(ram_ada), .ram_din(ram_din), .ram_cea(ram_cea),
        .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_oce(ram_oce),
        .ram_reset(ram_reset), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model plus a preload port and activity counters.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    int n_writes, n_ceb, n_oor_en;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_cea && int'(ram_ada) < DEPTH) mem[ram_ada] <= ram_din;
        if (ram_ceb && int'(ram_adb) < DEPTH) ram_dout <= mem[ram_adb];
        if (ram_cea) n_writes <= n_writes + 1;
        if (ram_ceb) n_ceb <= n_ceb + 1;
        if ((ram_cea && int'(ram_ada) >= DEPTH) || (ram_ceb && int'(ram_adb) >= DEPTH))
            n_oor_en <= n_oor_en + 1;
    end

    int n_checks, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold a CPU request until ack (bounded); lat counts cycles from the drive cycle to ack.
    task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           output logic [DW-1:0] rd, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = -1; rd = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = c;
                rd  = cpu_rdata;
                break;
            end
            tick();
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        logic [DW-1:0] rd;
        int lat;
        cpu_txn(1'b0, a, '0, rd, lat);
        check({nm, "_rdata"}, rd, exp);
        check({nm, "_lat"}, lat, 2);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        int lat, fw, first_c, last_c, done_c, ack_c, wr_c, w0, n_ack, n_val, n_miss, miss_c;
        logic busy1;

        vecs[0] = '{1'b1, 12'h123, 16'hBEEF, 16'h0000, 1};
        vecs[1] = '{1'b0, 12'h123, 16'h0000, 16'hBEEF, 2};
        vecs[2] = '{1'b1, 12'h000, 16'h1111, 16'h0000, 1};
        vecs[3] = '{1'b1, 12'hBFF, 16'h2222, 16'h0000, 1};
        vecs[4] = '{1'b0, 12'hBFF, 16'h0000, 16'h2222, 2};
        vecs[5] = '{1'b0, 12'h000, 16'h0000, 16'h1111, 2};
        vecs[6] = '{1'b1, 12'hC00, 16'hDEAD, 16'h0000, 1};
        vecs[7] = '{1'b0, 12'hC00, 16'h0000, 16'h0000, 2};
        vecs[8] = '{1'b0, 12'hFFF, 16'h0000, 16'h0000, 2};
        vecs[9] = '{1'b0, 12'h123, 16'h0000, 16'hBEEF, 2};

        n_checks = 0; n_fail = 0;
        n_writes = 0; n_ceb = 0; n_oor_en = 0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        resetn = 1'b0;
        vid_req = 1'b1; vid_addr = 12'h001;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;

        // Reset: enables gated even with a video request pending.
        tick(); tick();
        @(negedge clk);
        check("rst_ram_reset", ram_reset, 1);
        check("rst_ceb", ram_ceb, 0);
        check("rst_cea", ram_cea, 0);
        tick();
        resetn = 1'b1; vid_req = 1'b0;
        @(negedge clk);
        check("rst_outs", {vid_valid, vid_miss, cpu_ack, fill_busy, fill_done, ram_cea, ram_ceb}, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ram_reset_low", ram_reset, 0);
        check("rst_oce", ram_oce, 1);

        tick();
        for (int i = 0; i < 10; i++) begin
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = 16'h0100 + DW'(i);
            tick();
        end
        pre_we = 1'b0;
        tick();

        // Video burst: one result per request, two cycles after each request.
        for (int c = 0; c < 13; c++) begin
            vid_req = (c < 10); vid_addr = AW'(c);
            @(negedge clk);
            if (c < 10) check($sformatf("vid_ceb_c%0d", c), ram_ceb, 1);
            if (c >= 2 && c <= 11) begin
                check($sformatf("vid_valid_c%0d", c), vid_valid, 1);
                check($sformatf("vid_data_c%0d", c), vid_data, 32'h0100 + 32'(c - 2));
            end else begin
                check($sformatf("vid_idle_c%0d", c), vid_valid, 0);
            end
            tick();
        end
        vid_req = 1'b0;

        // CPU transaction table.
        for (int i = 0; i < 10; i++) begin
            cpu_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        check("oor_no_enable", n_oor_en, 0);

        // Fill with a CPU write arriving mid-fill.
        cpu_txn(1'b1, 12'h810, 16'hAAAA, rd, lat);
        fill_start = 1'b1; fill_base = 12'h7F0; fill_len = 12'h020; fill_value = 16'h0020;
        tick();
        fill_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 16'h5555;
        fw = 0; first_c = -1; last_c = -1; done_c = -1; ack_c = -1; wr_c = -1; busy1 = 1'b0;
        for (int c = 1; c < 80; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = fill_busy;
            if (ram_cea && ram_ada == 12'h005) wr_c = c;
            else if (ram_cea) begin
                fw++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (fill_done) begin
                done_c = c;
                check("fill_busy_at_done", fill_busy, 0);
            end
            if (cpu_ack) begin
                ack_c = c;
                break;
            end
            tick();
        end
        tick();
        cpu_req = 1'b0;
        check("fill_busy_c1", busy1, 1);
        check("fill_writes", fw, 32);
        check("fill_first", first_c, 1);
        check("fill_last", last_c, 32);
        check("fill_done_c", done_c, 33);
        check("fill_cpu_wr_issue", wr_c, 33);
        check("fill_cpu_ack", ack_c, 34);
        rd_check(12'h7F0, 16'h0020, "fill_7f0");
        rd_check(12'h80F, 16'h0020, "fill_80f");
        rd_check(12'h810, 16'hAAAA, "fill_810");
        rd_check(12'h005, 16'h5555, "fill_cpu_005");

        // Fill clipped at the end of the RAM, then an out-of-range CPU read.
        fill_start = 1'b1; fill_base = 12'hBFE; fill_len = 12'h005; fill_value = 16'h0042;
        tick();
        fill_start = 1'b0;
        fw = 0; done_c = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (ram_cea) fw++;
            if (fill_done) begin
                done_c = c;
                break;
            end
            tick();
        end
        tick();
        check("clip_writes", fw, 2);
        check("clip_done_c", done_c, 3);
        rd_check(12'hBFF, 16'h0042, "clip_bff");
        w0 = n_ceb;
        rd_check(12'hC00, 16'h0000, "oor_c00");
        check("oor_no_ceb", n_ceb - w0, 0);

        // Zero-length fill: straight to done, no writes.
        fill_start = 1'b1; fill_base = 12'h200; fill_len = 12'h000;
        tick();
        fill_start = 1'b0;
        @(negedge clk);
        check("len0_done", {fill_done, fill_busy, ram_cea}, 3'b100);
        tick();
        @(negedge clk);
        check("len0_after", {fill_done, fill_busy, ram_cea}, 3'b000);
        tick();

        // Continuous video traffic against a pending CPU read.
        n_val = 0; n_miss = 0; miss_c = -1; ack_c = -1; rd = '0;
        cpu_we = 1'b0; cpu_addr = 12'h123;
        for (int c = 0; c < 27; c++) begin
            vid_req = (c < 20); vid_addr = AW'(c % 10);
            cpu_req = (ack_c < 0);
            @(negedge clk);
            if (vid_valid) n_val++;
            if (vid_miss) begin
                n_miss++;
                miss_c = c;
            end
            if (cpu_ack && ack_c < 0) begin
                ack_c = c;
                rd = cpu_rdata;
            end
            tick();
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("starve_rdata", rd, 16'hBEEF);
`ifdef TEXT_RAM_ARB_STARVE_GUARD_EN
        check("starve_ack_c", ack_c, 10);
        check("starve_miss_n", n_miss, 1);
        check("starve_miss_c", miss_c, 10);
        check("starve_valid_n", n_val, 19);
`else
        check("starve_ack_c", ack_c, 22);
        check("starve_miss_n", n_miss, 0);
        check("starve_valid_n", n_val, 20);
`endif

        // Reset mid-fill and mid-CPU-read.
        tick();
        w0 = n_writes;
        fill_start = 1'b1; fill_base = 12'h100; fill_len = 12'h040; fill_value = 16'h7777;
        tick();
        fill_start = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        tick();
        resetn = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("mid_rst_cea_gated", ram_cea, 0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {vid_valid, vid_miss, cpu_ack, fill_busy, fill_done, ram_cea, ram_ceb}, 0);
        check("mid_rst_cpu_rdata", cpu_rdata, 0);
        check("mid_rst_vid_data", vid_data, 0);
        check("mid_rst_writes", n_writes - w0, 2);
        w0 = n_writes; n_ack = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            if (cpu_ack || fill_busy) n_ack++;
        end
        check("post_rst_quiet", n_ack, 0);
        check("post_rst_no_writes", n_writes - w0, 0);
        check("oor_no_enable_final", n_oor_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
Sequencer and arbiter in front of the 3072x16 text RAM. The RAM has a write port A and a read port B, and its read data is valid one cycle after the address is presented.
- Shares read port B between video scanout (priority) and CPU reads.
- Shares write port A between a hardware fill/clear engine (priority) and CPU writes.
- Sits between the display fetch, the CPU bus bridge and the RAM instance.

Parameters:
DEPTH, 3072, number of valid words; addresses >= DEPTH are out of range
AW, 12, address width
DW, 16, data width
MAX_WAIT, 8, starvation-guard threshold in cycles (used only with the optional feature)

Ports:
clk  in  1  single clock for the block and both RAM ports
resetn  in  1  synchronous, active-low reset
vid_req  in  1  video read request this cycle; pipelined, may be high every cycle
vid_addr  in  AW  video read address
vid_valid  out  1  vid_data valid (one-cycle pulse per served request)
vid_data  out  DW  video read data, registered
vid_miss  out  1  pulse: the video request from 2 cycles earlier was not served
cpu_req  in  1  CPU transaction request; held with addr/we/wdata stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  CPU read data, valid while cpu_ack is high after a read
fill_start  in  1  start-fill pulse; ignored while fill_busy is high
fill_base  in  AW  first fill address
fill_len  in  AW  number of words to fill
fill_value  in  DW  fill word
fill_busy  out  1  fill engine active
fill_done  out  1  one-cycle pulse when the fill completes
ram_ada, ram_din, ram_cea  out  AW/DW/1  port A address, data and write enable
ram_adb, ram_ceb  out  AW/1  port B address and enable
ram_oce  out  1  constant 1
ram_reset  out  1  equal to ~resetn
ram_dout  in  DW  port B read data, valid one cycle after ram_ceb

Behaviour:
- Reset (synchronous, resetn=0): all FSMs go idle and in-flight operations are dropped. Already-issued RAM writes persist. These outputs read 0: vid_valid, vid_miss, cpu_ack, fill_busy, fill_done, ram_cea, ram_ceb, vid_data, cpu_rdata.
- Port B arbitration, per cycle T:
  - vid_req=1 grants video.
  - Otherwise a pending, un-issued CPU read is granted.
  - The grantee's data is registered at the end of T+1 and presented at T+2.
  - Video: vid_valid=1 and vid_data at T+2; fully pipelined, one result per request.
  - CPU read: cpu_ack=1 and cpu_rdata at T+2.
- Port A arbitration: a running fill owns port A. A CPU write issues only when fill is not running: ram_cea=1 at T, cpu_ack=1 at T+1.
- CPU FSM states: C_IDLE, C_RD1, C_RD2, C_ACK.
  - No new CPU issue from issue cycle through the ack cycle inclusive; the requester drops or changes req after seeing ack.
  - The next issue can occur at the earliest the cycle after the ack.
- Out of range (addr >= DEPTH):
  - No RAM enable is asserted.
  - Read data returns 0 with normal latency; a CPU OOR read still waits for its port B slot.
  - CPU OOR write is acked at T+1 and the data is discarded.
- Fill FSM states: F_IDLE, F_RUN, F_DONE.
  - fill_start in F_IDLE latches base, len and value, enters F_RUN; fill_busy=1 from the next cycle.
  - F_RUN: one write per cycle at addr, addr+1, ...
  - Leave F_RUN after len writes, or when addr reaches DEPTH (clip, no wrap).
  - F_DONE: fill_done=1 for one cycle, fill_busy=0 in that cycle, then F_IDLE.
  - fill_len=0: F_DONE directly, zero writes.
- Simultaneous events:
  - fill_start and a CPU write in the same idle cycle: the CPU write issues that cycle, the fill's first write comes the next cycle.
  - A CPU write arriving during fill waits until F_DONE.
  - CPU reads proceed during fill.
  - No read-during-write forwarding; a same-address read returns old data.

Optional Feature:
TEXT_RAM_ARB_STARVE_GUARD_EN
- Defined:
  - A counter counts consecutive cycles in which a pending CPU read loses port B to video.
  - When the counter reaches MAX_WAIT, the next cycle grants the CPU regardless of vid_req, and the counter clears.
  - A video request dropped that cycle gets vid_miss=1 at T+2 with vid_valid=0.
- Undefined: video has absolute priority, a CPU read may wait indefinitely, and vid_miss is tied 0.

Test Plan:
1. vid_req held high 10 cycles, addr 0..9, RAM preloaded with word i = 0x0100+i -> vid_valid high cycles 2..11, vid_data 0x0100..0x0109 in order.
2. CPU write 0xBEEF to 0x123, then CPU read 0x123 with vid_req=0 -> write ack 1 cycle after issue; read ack 2 cycles after issue; cpu_rdata=0xBEEF.
3. fill_start base=0x7F0, len=0x20, value=0x0020; CPU write to 0x005 during fill -> 32 consecutive ram_cea cycles, then fill_done pulse; CPU write acked only after fill_done; 0x7F0..0x80F read 0x0020.
4. fill base=0xBFE, len=5 -> exactly 2 writes (0xBFE, 0xBFF), then fill_done; CPU read 0xC00 -> ack, rdata 0, ram_ceb never high.
5. vid_req held high 20 cycles plus a pending CPU read -> without macro: CPU ack only after vid_req drops. With macro and MAX_WAIT=8: CPU granted in the 9th cycle, one vid_miss pulse, cpu_ack 2 cycles later.
6. resetn low for 1 cycle mid-fill and mid-CPU-read -> next cycle all outputs at reset values, fill_busy=0, no cpu_ack, no further RAM writes.
